// File: rtl/midi_pkg.sv
// ---------------------------------------------------------------------------
// midi_pkg
// Shared types and constants for the MIDI stream parser:
//   - msg_type_e    : channel-voice message kinds, numbered like status[6:4]
//   - parse_state_e : parser states
//   - midi_msg_t    : one queued message {type, chan, d1, d2}, 21 bits
//   - SYSEX_START / SYSEX_END / RT_MIN status byte constants
// ---------------------------------------------------------------------------
package midi_pkg;

    typedef enum logic [2:0] {
        MSG_NOTE_OFF = 3'd0,
        MSG_NOTE_ON  = 3'd1,
        MSG_POLY_AT  = 3'd2,
        MSG_CC       = 3'd3,
        MSG_PROG     = 3'd4,
        MSG_CHAN_AT  = 3'd5,
        MSG_PITCH    = 3'd6
    } msg_type_e;

    typedef enum logic [1:0] {
        NO_STATUS = 2'd0,
        WAIT_D1   = 2'd1,
        WAIT_D2   = 2'd2,
        SYSEX     = 2'd3
    } parse_state_e;

    localparam logic [7:0] SYSEX_START = 8'hF0;
    localparam logic [7:0] SYSEX_END   = 8'hF7;
    localparam logic [7:0] RT_MIN      = 8'hF8;

    typedef struct packed {
        msg_type_e  mtype;
        logic [3:0] chan;
        logic [6:0] d1;
        logic [6:0] d2;
    } midi_msg_t;

    localparam int MSG_W = $bits(midi_msg_t);

    // Program change (Cx) and channel aftertouch (Dx) carry a single data byte.
    function automatic logic isOneDataByte(input logic [7:0] status);
        return (status[7:4] == 4'hC) || (status[7:4] == 4'hD);
    endfunction

endpackage

// File: rtl/midi_msg_fifo.sv
// ---------------------------------------------------------------------------
// midi_msg_fifo
// First-word-fall-through message queue.
//   clk, rst : clock, asynchronous active-high reset
//   push     : write wdata (ignored when full unless a pop happens the same cycle)
//   wdata    : word to write
//   full     : queue holds DEPTH words
//   valid    : head word present on rdata
//   pop      : remove the head (ignored while valid is low)
//   rdata    : head word, zero while the queue is empty
// ---------------------------------------------------------------------------
module midi_msg_fifo #(
    parameter int DEPTH = 4,
    parameter int WIDTH = 21
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] wdata,
    output logic             full,
    output logic             valid,
    input  logic             pop,
    output logic [WIDTH-1:0] rdata
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    // Pointers carry one wrap bit so full and empty can be told apart.
    logic [AW:0]      wrPtr_q;
    logic [AW:0]      rdPtr_q;
    logic [WIDTH-1:0] mem [DEPTH];
    logic             doPush;
    logic             doPop;

    assign valid  = (wrPtr_q != rdPtr_q);
    assign full   = (wrPtr_q[AW] != rdPtr_q[AW]) && (wrPtr_q[AW-1:0] == rdPtr_q[AW-1:0]);
    assign doPop  = pop && valid;
    // When full, a simultaneous pop frees the head slot, which is the slot being written.
    assign doPush = push && (!full || doPop);
    assign rdata  = valid ? mem[rdPtr_q[AW-1:0]] : '0;

    // Pointer bookkeeping; reset empties the queue.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wrPtr_q <= '0;
            rdPtr_q <= '0;
        end else begin
            if (doPush) wrPtr_q <= wrPtr_q + 1'b1;
            if (doPop)  rdPtr_q <= rdPtr_q + 1'b1;
        end
    end

    // Storage needs no reset: rdata is masked while the queue is empty.
    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr_q[AW-1:0]] <= wdata;
    end

endmodule

// File: rtl/midi_stream_parser.sv
// ---------------------------------------------------------------------------
// midi_stream_parser
// Turns a raw MIDI byte stream into channel-voice messages with running
// status, real-time filtering and SysEx skipping, then queues them.
//   Parameters: FIFO_DEPTH (queue depth), CHAN_EN (channel accept mask),
//               VEL0_IS_OFF (note-on velocity 0 reported as note-off)
//   clk, rst   : clock, asynchronous active-high reset
//   byte_in    : incoming MIDI byte, consumed when byte_valid is high
//   msg_valid  : queue head holds a message; msg_ready pops it
//   msg_type/msg_chan/msg_d1/msg_d2 : head message fields
//   drop_cnt   : saturating count of messages lost to a full queue
// ---------------------------------------------------------------------------
module midi_stream_parser
    import midi_pkg::*;
#(
    parameter int          FIFO_DEPTH  = 4,
    parameter logic [15:0] CHAN_EN     = 16'hFFFF,
    parameter bit          VEL0_IS_OFF = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] byte_in,
    input  logic       byte_valid,
    output logic       msg_valid,
    input  logic       msg_ready,
    output logic [2:0] msg_type,
    output logic [3:0] msg_chan,
    output logic [6:0] msg_d1,
    output logic [6:0] msg_d2,
    output logic [7:0] drop_cnt
);

    parse_state_e state_q, state_d;
    logic [7:0]   runStatus_q, runStatus_d;
    logic [6:0]   d1_q, d1_d;
    logic [7:0]   dropCnt_q, dropCnt_d;
    logic         msgDone;
    logic [6:0]   d1Val;
    logic [6:0]   d2Val;
    midi_msg_t    msgNew;
    midi_msg_t    msgHead;
    logic         push;
    logic         pop;
    logic         fifoFull;

    // Parser registers; reset drops running status and any partial message.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= NO_STATUS;
            runStatus_q <= '0;
            d1_q        <= '0;
            dropCnt_q   <= '0;
        end else begin
            state_q     <= state_d;
            runStatus_q <= runStatus_d;
            d1_q        <= d1_d;
            dropCnt_q   <= dropCnt_d;
        end
    end

    // Next-state logic. Real-time bytes fall outside every branch, so they
    // leave state, running status and the latched first data byte untouched.
    always_comb begin
        state_d     = state_q;
        runStatus_d = runStatus_q;
        d1_d        = d1_q;
        msgDone     = 1'b0;
        d1Val       = d1_q;
        d2Val       = '0;
        if (byte_valid && (byte_in < RT_MIN)) begin
            if (byte_in[7]) begin
                if (state_q == SYSEX) begin
                    // Inside SysEx only the terminator matters.
                    if (byte_in == SYSEX_END) state_d = NO_STATUS;
                end else if (byte_in < SYSEX_START) begin
                    runStatus_d = byte_in;
                    d1_d        = '0;
                    state_d     = WAIT_D1;
                end else begin
                    runStatus_d = '0;
                    d1_d        = '0;
                    state_d     = (byte_in == SYSEX_START) ? SYSEX : NO_STATUS;
                end
            end else begin
                case (state_q)
                    WAIT_D1: begin
                        d1_d = byte_in[6:0];
                        if (isOneDataByte(runStatus_q)) begin
                            msgDone = 1'b1;
                            d1Val   = byte_in[6:0];
                        end else begin
                            state_d = WAIT_D2;
                        end
                    end
                    WAIT_D2: begin
                        msgDone = 1'b1;
                        d2Val   = byte_in[6:0];
                        state_d = WAIT_D1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Build the completed message, filter by channel and count queue overflows.
    always_comb begin
        msgNew       = '0;
        msgNew.mtype = msg_type_e'(runStatus_q[6:4]);
        msgNew.chan  = runStatus_q[3:0];
        msgNew.d1    = d1Val;
        msgNew.d2    = d2Val;
        if (VEL0_IS_OFF && (msgNew.mtype == MSG_NOTE_ON) && (d2Val == 7'd0)) begin
            msgNew.mtype = MSG_NOTE_OFF;
        end
        push      = msgDone && CHAN_EN[runStatus_q[3:0]];
        dropCnt_d = dropCnt_q;
        if (push && fifoFull && !pop && (dropCnt_q != 8'hFF)) begin
            dropCnt_d = dropCnt_q + 8'd1;
        end
    end

    assign pop = msg_ready && msg_valid;

    midi_msg_fifo #(
        .DEPTH (FIFO_DEPTH),
        .WIDTH (MSG_W)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (push),
        .wdata (msgNew),
        .full  (fifoFull),
        .valid (msg_valid),
        .pop   (msg_ready),
        .rdata (msgHead)
    );

    assign msg_type = msgHead.mtype;
    assign msg_chan = msgHead.chan;
    assign msg_d1   = msgHead.d1;
    assign msg_d2   = msgHead.d2;
    assign drop_cnt = dropCnt_q;

endmodule

// File: tb/tb_midi_stream_parser.sv
// ---------------------------------------------------------------------------
// tb_midi_stream_parser
// Two parser instances with different parameters share one byte stream and
// one ready signal. A stream-level reference model predicts messages into
// per-instance scoreboard queues; a monitor compares every popped head.
// ---------------------------------------------------------------------------
module tb_midi_stream_parser;

    localparam int          DEPTH_A = 4;
    localparam logic [15:0] MASK_A  = 16'hFFFF;
    localparam bit          VEL0_A  = 1'b1;
    localparam int          DEPTH_B = 2;
    localparam logic [15:0] MASK_B  = 16'hA5A5;
    localparam bit          VEL0_B  = 1'b0;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] byteIn = '0;
    logic       byteValid = 1'b0;
    logic       msgReady = 1'b0;

    logic       vld  [2];
    logic [2:0] typ  [2];
    logic [3:0] chn  [2];
    logic [6:0] dA   [2];
    logic [6:0] dB   [2];
    logic [7:0] drop [2];

    // Reference model state: running status, SysEx flag, collected data bytes.
    bit          haveRun;
    logic [7:0]  runSt;
    bit          inSysex;
    logic [6:0]  pend [$];
    logic [20:0] expQ [2][$];
    int          occ [2];
    int          expDrop [2];
    logic [7:0]  seq [$];

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    midi_stream_parser #(.FIFO_DEPTH(DEPTH_A), .CHAN_EN(MASK_A), .VEL0_IS_OFF(VEL0_A)) dutA (
        .clk(clk), .rst(rst), .byte_in(byteIn), .byte_valid(byteValid),
        .msg_valid(vld[0]), .msg_ready(msgReady), .msg_type(typ[0]), .msg_chan(chn[0]),
        .msg_d1(dA[0]), .msg_d2(dB[0]), .drop_cnt(drop[0])
    );

    midi_stream_parser #(.FIFO_DEPTH(DEPTH_B), .CHAN_EN(MASK_B), .VEL0_IS_OFF(VEL0_B)) dutB (
        .clk(clk), .rst(rst), .byte_in(byteIn), .byte_valid(byteValid),
        .msg_valid(vld[1]), .msg_ready(msgReady), .msg_type(typ[1]), .msg_chan(chn[1]),
        .msg_d1(dA[1]), .msg_d2(dB[1]), .drop_cnt(drop[1])
    );

    function automatic int cfgDepth(input int i);
        return (i == 0) ? DEPTH_A : DEPTH_B;
    endfunction

    function automatic logic [15:0] cfgMask(input int i);
        return (i == 0) ? MASK_A : MASK_B;
    endfunction

    function automatic bit cfgVel0(input int i);
        return (i == 0) ? VEL0_A : VEL0_B;
    endfunction

    task automatic checkOutput(input string name, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic modelReset();
        haveRun = 1'b0;
        runSt   = '0;
        inSysex = 1'b0;
        pend.delete();
        for (int i = 0; i < 2; i++) begin
            expQ[i].delete();
            occ[i]     = 0;
            expDrop[i] = 0;
        end
    endtask

    // Stream rules: real-time ignored, SysEx swallowed until F7, channel
    // status starts a fresh message, data bytes collect until the message
    // has its one or two bytes.
    task automatic modelByte(input logic [7:0] b, output bit done, output logic [7:0] st,
                             output logic [6:0] a, output logic [6:0] c);
        int need;
        done = 1'b0;
        st   = runSt;
        a    = '0;
        c    = '0;
        if (b >= 8'hF8) return;
        if (b[7]) begin
            if (inSysex) begin
                if (b == 8'hF7) inSysex = 1'b0;
            end else if (b < 8'hF0) begin
                haveRun = 1'b1;
                runSt   = b;
                pend.delete();
            end else begin
                haveRun = 1'b0;
                pend.delete();
                inSysex = (b == 8'hF0);
            end
        end else if (!inSysex && haveRun) begin
            pend.push_back(b[6:0]);
            need = (runSt[7:4] == 4'hC || runSt[7:4] == 4'hD) ? 1 : 2;
            if (pend.size() == need) begin
                done = 1'b1;
                st   = runSt;
                a    = pend[0];
                c    = (need == 2) ? pend[1] : 7'd0;
                pend.delete();
            end
        end
    endtask

    // Drive one cycle of inputs at the falling edge and advance the model to
    // the following rising edge. msg_valid is checked against the model's
    // queue occupancy first, which also covers the one-cycle push latency.
    task automatic applyStimulus(input logic [7:0] b, input bit v, input bit rdy);
        bit          done;
        bit          pop;
        logic [7:0]  st;
        logic [6:0]  a, c;
        logic [2:0]  t;
        logic [15:0] m;
        @(negedge clk);
        for (int i = 0; i < 2; i++) checkOutput($sformatf("valid%0d", i), vld[i], (occ[i] > 0) ? 1 : 0);
        byteIn    = b;
        byteValid = v;
        msgReady  = rdy;
        done = 1'b0;
        st = '0;
        a = '0;
        c = '0;
        if (v) modelByte(b, done, st, a, c);
        for (int i = 0; i < 2; i++) begin
            pop = rdy && (occ[i] > 0);
            m   = cfgMask(i);
            if (done && m[st[3:0]]) begin
                t = st[6:4];
                if (cfgVel0(i) && t == 3'd1 && c == 7'd0) t = 3'd0;
                if (occ[i] == cfgDepth(i) && !pop) begin
                    if (expDrop[i] < 255) expDrop[i]++;
                end else begin
                    expQ[i].push_back({t, st[3:0], a, c});
                    occ[i]++;
                end
            end
            if (pop) occ[i]--;
        end
    endtask

    task automatic sendSeq(input bit rdy);
        foreach (seq[k]) applyStimulus(seq[k], 1'b1, rdy);
    endtask

    task automatic idle(input int n);
        repeat (n) applyStimulus(8'h00, 1'b0, 1'b1);
    endtask

    task automatic checkDrops();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("drop%0d", i), drop[i], expDrop[i]);
            checkOutput($sformatf("leftover%0d", i), expQ[i].size(), 0);
        end
    endtask

    task automatic resetDut();
        @(negedge clk);
        rst       = 1'b1;
        byteValid = 1'b0;
        msgReady  = 1'b0;
        modelReset();
        repeat (2) @(negedge clk);
        rst = 1'b0;
    endtask

    function automatic logic [7:0] randByte();
        int r;
        r = $urandom_range(0, 99);
        if (r < 50) return {1'b0, 7'($urandom)};
        if (r < 75) return 8'h80 + 8'($urandom_range(0, 111));
        if (r < 85) return 8'hF8 + 8'($urandom_range(0, 7));
        if (r < 92) return ($urandom_range(0, 1) == 1) ? 8'hF0 : 8'hF7;
        return 8'hF1 + 8'($urandom_range(0, 5));
    endfunction

    // Monitor: just before each rising edge, a head that is valid and ready
    // is being popped; it must match the oldest predicted message.
    initial begin
        logic [20:0] e;
        forever begin
            @(negedge clk);
            #3;
            if (!rst && msgReady) begin
                for (int i = 0; i < 2; i++) begin
                    if (vld[i]) begin
                        if (expQ[i].size() == 0) begin
                            tests++;
                            fails++;
                            $display("[TB] FAIL extra%0d: got %0h, expected no message", i,
                                     {typ[i], chn[i], dA[i], dB[i]});
                        end else begin
                            e = expQ[i].pop_front();
                            checkOutput($sformatf("msg%0d", i), {typ[i], chn[i], dA[i], dB[i]}, e);
                        end
                    end
                end
            end
        end
    end

    initial begin
        modelReset();
        resetDut();
        for (int i = 0; i < 2; i++) begin
            checkOutput($sformatf("rst_valid%0d", i), vld[i], 0);
            checkOutput($sformatf("rst_type%0d", i), typ[i], 0);
            checkOutput($sformatf("rst_chan%0d", i), chn[i], 0);
            checkOutput($sformatf("rst_d1_%0d", i), dA[i], 0);
            checkOutput($sformatf("rst_d2_%0d", i), dB[i], 0);
            checkOutput($sformatf("rst_drop%0d", i), drop[i], 0);
        end

        // Single note held at the head; fields are checked as constants.
        seq = '{8'h90, 8'h3C, 8'h64};
        sendSeq(1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("note_valid", vld[0], 1);
        checkOutput("note_type", typ[0], 1);
        checkOutput("note_chan", chn[0], 0);
        checkOutput("note_d1", dA[0], 8'h3C);
        checkOutput("note_d2", dB[0], 8'h64);
        idle(3);

        // Running status with velocity-0 note-on.
        seq = '{8'h93, 8'h40, 8'h7F, 8'h41, 8'h00};
        sendSeq(1'b1);
        idle(3);

        // Real-time inside a message, then a one-data-byte message.
        seq = '{8'hB0, 8'h07, 8'hF8, 8'h64, 8'hC5, 8'h0A};
        sendSeq(1'b1);
        idle(3);

        // SysEx swallowed, stray data ignored, then a fresh note-off.
        seq = '{8'hF0, 8'h7E, 8'h01, 8'hF7, 8'h3C, 8'h40, 8'h80, 8'h3C, 8'h40};
        sendSeq(1'b1);
        idle(3);

        // Channel 1 is masked off in the second instance.
        seq = '{8'h91, 8'h3C, 8'h64};
        sendSeq(1'b1);
        idle(3);
        checkOutput("mask_drop1", drop[1], 0);
        checkDrops();

        // Overflow: six notes with no consumer.
        resetDut();
        seq = '{8'h90, 8'h3C, 8'h64, 8'h3D, 8'h64, 8'h3E, 8'h64,
                8'h3F, 8'h64, 8'h40, 8'h64, 8'h41, 8'h64};
        sendSeq(1'b0);
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("ovf_drop0", drop[0], 2);
        checkOutput("ovf_drop1", drop[1], 4);
        idle(8);
        checkDrops();

        // Reset in the middle of a message discards it.
        seq = '{8'h90, 8'h3C};
        sendSeq(1'b1);
        resetDut();
        seq = '{8'h64};
        sendSeq(1'b1);
        idle(3);
        checkDrops();

        // Drop counter saturates.
        resetDut();
        applyStimulus(8'h90, 1'b1, 1'b0);
        for (int k = 0; k < 300; k++) begin
            applyStimulus(8'h30, 1'b1, 1'b0);
            applyStimulus(8'h50, 1'b1, 1'b0);
        end
        applyStimulus(8'h00, 1'b0, 1'b0);
        checkOutput("sat_drop0", drop[0], 255);
        checkOutput("sat_drop1", drop[1], 255);
        idle(8);
        checkDrops();

        // Randomised stream with a bursty consumer.
        resetDut();
        for (int k = 0; k < 3000; k++) begin
            applyStimulus(randByte(), ($urandom_range(0, 9) < 8) ? 1'b1 : 1'b0,
                          ($urandom_range(0, 9) < 4) ? 1'b1 : 1'b0);
        end
        idle(10);
        checkDrops();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
